// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side buffer.
//   DATA_W     : width of one transmitted byte
//   tx_state_t : handshake FSM state encoding used by uart_tx_fifo
package uart_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LOAD      = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_GAP       = 2'd3
    } tx_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Circular byte FIFO with occupancy count and sticky overflow flag.
// Ports:
//   clk, srst      : clock, synchronous active-high reset
//   wr_en, wr_byte : enqueue strobe and data (dropped when full)
//   clr_ovf        : clears the sticky overflow flag
//   pop            : dequeue strobe (ignored when empty)
//   head_byte      : byte at the head of the queue (combinational)
//   empty, full    : occupancy flags
//   count          : number of stored bytes, 0..DEPTH
//   overflow       : sticky, set when a write was dropped
module byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_byte,
    input  logic              clr_ovf,
    input  logic              pop,
    output logic [DATA_W-1:0] head_byte,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overflow
);

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [ADDR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [ADDR_W:0]   count_reg, count_next;
    logic              overflow_reg, overflow_next;
    logic              wr_ok;
    logic              pop_ok;

    assign empty     = (count_reg == '0);
    assign full      = (count_reg == DEPTH_CNT);
    assign count     = count_reg;
    assign overflow  = overflow_reg;
    assign head_byte = mem_reg[rd_ptr_reg];

    // Fullness is judged on the pre-edge count, so a write into a full
    // FIFO is dropped even when a pop frees a slot on the same edge.
    assign wr_ok  = wr_en && !full;
    assign pop_ok = pop && !empty;

    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        overflow_next = overflow_reg;

        // Pointers are exactly ADDR_W bits, so the +1 wraps DEPTH-1 -> 0.
        if (wr_ok) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
        end

        case ({wr_ok, pop_ok})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase

        // A dropped write beats a clear in the same cycle.
        if (wr_en && full) begin
            overflow_next = 1'b1;
        end else if (clr_ovf) begin
            overflow_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_reg[wr_ptr_reg] <= wr_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit-side byte buffer feeding a UART transmitter.
// Bytes written from the bus are queued in byte_fifo and launched one at a
// time to the transmitter through a held valid / active / done handshake.
// Ports:
//   i_Clock, i_Reset         : clock, synchronous active-high reset
//   i_Wr_En, i_Wr_Byte       : enqueue strobe and byte
//   i_Clr_Ovf                : clears o_Overflow
//   o_Empty, o_Full, o_Count : FIFO status
//   o_Overflow               : sticky dropped-write flag
//   o_Busy                   : FIFO non-empty or a byte is in flight
//   o_Tx_DV, o_Tx_Byte       : valid and byte to the transmitter
//   i_Tx_Active, i_Tx_Done   : transmitter busy level and done pulse
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    input  logic              i_Wr_En,
    input  logic [DATA_W-1:0] i_Wr_Byte,
    input  logic              i_Clr_Ovf,
    output logic              o_Empty,
    output logic              o_Full,
    output logic [ADDR_W:0]   o_Count,
    output logic              o_Overflow,
    output logic              o_Busy,
    output logic              o_Tx_DV,
    output logic [DATA_W-1:0] o_Tx_Byte,
    input  logic              i_Tx_Active,
    input  logic              i_Tx_Done
);

    tx_state_t         state_reg, state_next;
    logic              tx_dv_reg, tx_dv_next;
    logic [DATA_W-1:0] tx_byte_reg, tx_byte_next;
    logic              pop;
    logic [DATA_W-1:0] head_byte;
    logic              fifo_empty;

    byte_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk       (i_Clock),
        .srst      (i_Reset),
        .wr_en     (i_Wr_En),
        .wr_byte   (i_Wr_Byte),
        .clr_ovf   (i_Clr_Ovf),
        .pop       (pop),
        .head_byte (head_byte),
        .empty     (fifo_empty),
        .full      (o_Full),
        .count     (o_Count),
        .overflow  (o_Overflow)
    );

    always_comb begin
        state_next   = state_reg;
        tx_byte_next = tx_byte_reg;
        pop          = 1'b0;

        case (state_reg)
            S_IDLE: begin
                // The Active guard keeps us from launching into a transmitter
                // that is still finishing a frame started before a reset.
                if (!fifo_empty && !i_Tx_Active && !i_Tx_Done) begin
                    state_next   = S_LOAD;
                    tx_byte_next = head_byte;
                    pop          = 1'b1;
                end
            end
            S_LOAD: begin
                if (i_Tx_Active) begin
                    state_next = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (i_Tx_Done) begin
                    state_next = S_GAP;
                end
            end
            S_GAP: begin
                // One dead cycle so the done pulse is gone before the next launch.
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Valid is held for the whole S_LOAD stay, not pulsed.
        tx_dv_next = (state_next == S_LOAD);
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_reg   <= S_IDLE;
            tx_dv_reg   <= 1'b0;
            tx_byte_reg <= '0;
        end else begin
            state_reg   <= state_next;
            tx_dv_reg   <= tx_dv_next;
            tx_byte_reg <= tx_byte_next;
        end
    end

    assign o_Empty   = fifo_empty;
    assign o_Tx_DV   = tx_dv_reg;
    assign o_Tx_Byte = tx_byte_reg;
    assign o_Busy    = !fifo_empty || (state_reg != S_IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a serial UART transmitter model,
// a line receiver, and a queue-based reference of the FIFO contents.
module tb_uart_tx_fifo;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int CPB    = 4;

    logic              i_Clock = 1'b0;
    logic              i_Reset;
    logic              i_Wr_En;
    logic [7:0]        i_Wr_Byte;
    logic              i_Clr_Ovf;
    logic              o_Empty;
    logic              o_Full;
    logic [ADDR_W:0]   o_Count;
    logic              o_Overflow;
    logic              o_Busy;
    logic              o_Tx_DV;
    logic [7:0]        o_Tx_Byte;
    logic              i_Tx_Active;
    logic              i_Tx_Done;

    always #5 i_Clock = ~i_Clock;

    uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .i_Clock     (i_Clock),
        .i_Reset     (i_Reset),
        .i_Wr_En     (i_Wr_En),
        .i_Wr_Byte   (i_Wr_Byte),
        .i_Clr_Ovf   (i_Clr_Ovf),
        .o_Empty     (o_Empty),
        .o_Full      (o_Full),
        .o_Count     (o_Count),
        .o_Overflow  (o_Overflow),
        .o_Busy      (o_Busy),
        .o_Tx_DV     (o_Tx_DV),
        .o_Tx_Byte   (o_Tx_Byte),
        .i_Tx_Active (i_Tx_Active),
        .i_Tx_Done   (i_Tx_Done)
    );

    int n_compared   = 0;
    int n_mismatched = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            if (n_mismatched <= 40)
                $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- UART transmitter model (not reset by i_Reset) ----------
    logic       u_active  = 1'b0;
    logic       u_done    = 1'b0;
    logic       tx_serial = 1'b1;
    logic       hold_busy = 1'b0;
    logic [9:0] u_frame   = '1;
    int         u_bit     = 0;
    int         u_clk     = 0;

    assign i_Tx_Active = u_active | hold_busy;
    assign i_Tx_Done   = u_done;

    always @(posedge i_Clock) begin
        u_done <= 1'b0;
        if (!u_active) begin
            if (o_Tx_DV === 1'b1) begin
                u_active  <= 1'b1;
                u_frame   <= {1'b1, o_Tx_Byte, 1'b0};
                u_bit     <= 0;
                u_clk     <= 0;
                tx_serial <= 1'b0;
            end
        end else if (u_clk == CPB - 1) begin
            u_clk <= 0;
            if (u_bit == 9) begin
                u_active  <= 1'b0;
                u_done    <= 1'b1;
                tx_serial <= 1'b1;
            end else begin
                u_bit     <= u_bit + 1;
                tx_serial <= u_frame[u_bit + 1];
            end
        end else begin
            u_clk <= u_clk + 1;
        end
    end

    // ---------------- reference model ----------------------------------------
    logic [7:0] model_q[$];   // bytes accepted, not yet launched
    logic [7:0] exp_rx_q[$];  // bytes launched, not yet seen on the line
    logic       exp_ovf  = 1'b0;
    logic [7:0] last_tx  = '0;
    int         rx_total = 0;
    logic [7:0] last_rx  = '0;

    // Serial line receiver: samples mid-bit, LSB first.
    always begin
        logic [7:0] rb;
        @(negedge tx_serial);
        repeat (CPB / 2) @(posedge i_Clock);
        check("rx_start", {31'd0, tx_serial}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(posedge i_Clock);
            rb[i] = tx_serial;
        end
        repeat (CPB) @(posedge i_Clock);
        check("rx_stop", {31'd0, tx_serial}, 32'd1);
        if (exp_rx_q.size() == 0) begin
            check("rx_unexpected", {24'd0, rb}, 32'h100);
        end else begin
            logic [7:0] eb;
            eb = exp_rx_q.pop_front();
            check("rx_byte", {24'd0, rb}, {24'd0, eb});
        end
        rx_total++;
        last_rx = rb;
        $display("rx byte %0d: 0x%02h", rx_total, rb);
    end

    // Per-edge monitor: update the reference from what was presented at the
    // edge, then compare the status outputs.
    always begin
        logic       pre_rst, pre_wr, pre_clr, pre_dv, pre_act, pre_done, full_pre, launched;
        logic [7:0] pre_byte;
        @(posedge i_Clock);
        pre_rst  = i_Reset;
        pre_wr   = i_Wr_En;
        pre_byte = i_Wr_Byte;
        pre_clr  = i_Clr_Ovf;
        pre_dv   = o_Tx_DV;
        pre_act  = i_Tx_Active;
        pre_done = i_Tx_Done;
        #1;
        if (pre_rst === 1'b1) begin
            model_q.delete();
            exp_ovf = 1'b0;
            check("rst_dv",   {31'd0, o_Tx_DV}, 32'd0);
            check("rst_byte", {24'd0, o_Tx_Byte}, 32'd0);
            check("rst_busy", {31'd0, o_Busy}, 32'd0);
        end else begin
            full_pre = (model_q.size() == DEPTH);
            launched = (o_Tx_DV === 1'b1) && (pre_dv === 1'b0);
            if (launched) begin
                check("launch_guard", {30'd0, pre_act, pre_done}, 32'd0);
                if (model_q.size() == 0) begin
                    check("launch_from_empty", {24'd0, o_Tx_Byte}, 32'h100);
                end else begin
                    logic [7:0] hb;
                    hb = model_q.pop_front();
                    check("tx_byte", {24'd0, o_Tx_Byte}, {24'd0, hb});
                    exp_rx_q.push_back(hb);
                    last_tx = hb;
                end
            end else if (pre_dv === 1'b1 && o_Tx_DV === 1'b1) begin
                check("tx_byte_hold", {24'd0, o_Tx_Byte}, {24'd0, last_tx});
            end
            if (pre_wr === 1'b1 && full_pre)   exp_ovf = 1'b1;
            else if (pre_clr === 1'b1)         exp_ovf = 1'b0;
            if (pre_wr === 1'b1 && !full_pre)  model_q.push_back(pre_byte);
        end
        check("count",    {27'd0, o_Count}, model_q.size());
        check("empty",    {31'd0, o_Empty}, {31'd0, model_q.size() == 0});
        check("full",     {31'd0, o_Full},  {31'd0, model_q.size() == DEPTH});
        check("overflow", {31'd0, o_Overflow}, {31'd0, exp_ovf});
    end

    // ---------------- stimulus helpers ---------------------------------------
    task automatic wr(input logic [7:0] b);
        i_Wr_En   = 1'b1;
        i_Wr_Byte = b;
        @(negedge i_Clock);
        i_Wr_En   = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (!(model_q.size() == 0 && exp_rx_q.size() == 0 && o_Busy == 1'b0 &&
                 i_Tx_Active == 1'b0 && i_Tx_Done == 1'b0) && n < budget) begin
            @(negedge i_Clock);
            n++;
        end
        check("drain_in_time", {31'd0, n < budget}, 32'd1);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rx_base;
        int peak;
        int n;
        i_Reset   = 1'b1;
        i_Wr_En   = 1'b0;
        i_Wr_Byte = '0;
        i_Clr_Ovf = 1'b0;
        repeat (2) @(negedge i_Clock);
        i_Reset = 1'b0;

        // Reset then idle.
        repeat (100) begin
            @(negedge i_Clock);
            check("idle_empty", {31'd0, o_Empty}, 32'd1);
            check("idle_dv",    {31'd0, o_Tx_DV}, 32'd0);
            check("idle_busy",  {31'd0, o_Busy},  32'd0);
        end

        // Single byte: DV two cycles after the write, held until Active.
        rx_base = rx_total;
        wr(8'hA5);
        check("single_dv_early", {31'd0, o_Tx_DV}, 32'd0);
        @(negedge i_Clock);
        check("single_dv_rise", {31'd0, o_Tx_DV}, 32'd1);
        check("single_byte",    {24'd0, o_Tx_Byte}, 32'hA5);
        @(negedge i_Clock);
        check("single_dv_held", {30'd0, o_Tx_DV, i_Tx_Active}, 32'd3);
        @(negedge i_Clock);
        check("single_dv_fall", {31'd0, o_Tx_DV}, 32'd0);
        n = 0;
        while (i_Tx_Done !== 1'b1 && n < 200) begin
            @(negedge i_Clock);
            n++;
        end
        check("single_done_seen", {31'd0, n < 200}, 32'd1);
        @(negedge i_Clock);
        check("single_busy_gap", {31'd0, o_Busy}, 32'd1);
        @(negedge i_Clock);
        check("single_busy_clear", {31'd0, o_Busy}, 32'd0);
        wait_idle(200);
        check("single_rx_count", rx_total - rx_base, 32'd1);
        check("single_rx_value", {24'd0, last_rx}, 32'hA5);

        // Burst of three back-to-back writes.
        rx_base = rx_total;
        peak = 0;
        wr(8'h00); if (o_Count > peak) peak = o_Count;
        wr(8'hFF); if (o_Count > peak) peak = o_Count;
        wr(8'h55); if (o_Count > peak) peak = o_Count;
        check("burst_peak", {31'd0, peak == 2 || peak == 3}, 32'd1);
        wait_idle(1000);
        check("burst_rx_count", rx_total - rx_base, 32'd3);
        check("burst_last",     {24'd0, last_rx}, 32'h55);

        // Fill with the transmitter held busy, then overflow.
        rx_base = rx_total;
        hold_busy = 1'b1;
        for (int i = 0; i < 17; i++) begin
            wr(8'h10 + 8'(i));
            if (i == 15) begin
                check("fill_full",  {31'd0, o_Full}, 32'd1);
                check("fill_count", {27'd0, o_Count}, 32'd16);
            end
        end
        check("ovf_set",     {31'd0, o_Overflow}, 32'd1);
        check("held_busy",   {31'd0, o_Busy}, 32'd1);
        check("held_no_dv",  {31'd0, o_Tx_DV}, 32'd0);
        i_Wr_En = 1'b1; i_Wr_Byte = 8'h21; i_Clr_Ovf = 1'b1;
        @(negedge i_Clock);
        i_Wr_En = 1'b0; i_Clr_Ovf = 1'b1;
        check("ovf_set_wins", {31'd0, o_Overflow}, 32'd1);
        @(negedge i_Clock);
        i_Clr_Ovf = 1'b0;
        check("ovf_cleared", {31'd0, o_Overflow}, 32'd0);
        hold_busy = 1'b0;
        wait_idle(2000);
        check("fill_rx_count", rx_total - rx_base, 32'd16);
        check("fill_last",     {24'd0, last_rx}, 32'h1F);

        // Wrap-around: three rounds of 12 random bytes.
        rx_base = rx_total;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 12; i++) wr(8'($urandom));
            wait_idle(2000);
        end
        check("wrap_rx_count", rx_total - rx_base, 32'd36);

        // Random traffic with random back-pressure and overflow clears.
        for (int c = 0; c < 400; c++) begin
            i_Wr_En   = ($urandom_range(0, 1) == 1);
            i_Wr_Byte = 8'($urandom);
            i_Clr_Ovf = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 31) == 0) hold_busy = ~hold_busy;
            @(negedge i_Clock);
        end
        i_Wr_En = 1'b0; i_Clr_Ovf = 1'b0; hold_busy = 1'b0;
        wait_idle(3000);

        // Mid-frame reset with bytes queued.
        for (int i = 0; i < 6; i++) wr(8'h60 + 8'(i));
        n = 0;
        while (!(o_Tx_DV == 1'b0 && i_Tx_Active == 1'b1 && o_Count == 5) && n < 100) begin
            @(negedge i_Clock);
            n++;
        end
        check("midrst_reached", {31'd0, n < 100}, 32'd1);
        i_Reset = 1'b1;
        @(negedge i_Clock);
        i_Reset = 1'b0;
        check("midrst_count", {27'd0, o_Count}, 32'd0);
        check("midrst_dv",    {31'd0, o_Tx_DV}, 32'd0);
        wr(8'h3C);
        n = 0;
        while (i_Tx_Active == 1'b1 && n < 100) begin
            check("midrst_no_launch", {31'd0, o_Tx_DV}, 32'd0);
            @(negedge i_Clock);
            n++;
        end
        wait_idle(500);
        check("midrst_last", {24'd0, last_rx}, 32'h3C);

        repeat (5) @(negedge i_Clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
